// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man motion and maze-lookup blocks.
package pacman_pkg;

  localparam int unsigned N_ACTORS   = 5;
  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requester at or above i_ptr, else lowest overall.
module rr_pick #(
  parameter  int unsigned N_REQ = 5,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick_c,
  output logic             o_any_c
);

  logic w_found;

  always_comb begin
    o_pick_c = '0;
    w_found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[i] && (PTR_W'(i) >= i_ptr)) begin
        o_pick_c[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
    // Nothing at or above the pointer: wrap to the lowest index.
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_pick_c[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  assign o_any_c = |i_req;

endmodule

// File: rtl/wall_query_arbiter.sv
// Shares the single wall-collision lookup among Pac-Man and the ghosts, one query at a time.
module wall_query_arbiter
  import pacman_pkg::*;
#(
  parameter int unsigned N_REQ      = N_ACTORS,
  parameter int unsigned LOOKUP_LAT = 2,
  parameter int unsigned COORD_W    = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*COORD_W-1:0] i_req_x,
  input  logic [N_REQ*COORD_W-1:0] i_req_y,
  input  logic [2*N_REQ-1:0]       i_req_dir,
  output logic                     o_q_valid,
  output logic [COORD_W-1:0]       o_q_x,
  output logic [COORD_W-1:0]       o_q_y,
  output logic [1:0]               o_q_dir,
  input  logic                     i_q_blocked,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_resp_valid,
  output logic [N_REQ-1:0]         o_resp_blocked,
  output logic                     o_busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(LOOKUP_LAT - 1);

  arb_state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]        r_rr_ptr, w_rr_ptr_nxt, w_ptr_in, w_ptr_after;
  logic [PTR_W-1:0]        r_win_idx, w_win_idx_nxt, w_pick_idx;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic [N_REQ-1:0]        w_pick;
  logic                    w_any, w_load;
  logic [COORD_W-1:0]      w_sel_x, w_sel_y, w_q_x_nxt, w_q_y_nxt;
  dir_t                    w_sel_dir;
  logic [1:0]              w_q_dir_nxt;
  logic                    w_q_valid_nxt, w_busy_nxt;
  logic [N_REQ-1:0]        w_gnt_nxt, w_resp_valid_nxt, w_resp_blocked_nxt;

  // In RESP the pointer already advances past the finishing winner for the back-to-back pick.
  assign w_ptr_after = (r_win_idx == PTR_W'(N_REQ - 1)) ? '0 : r_win_idx + PTR_W'(1);
  assign w_ptr_in    = (r_state == RESP) ? w_ptr_after : r_rr_ptr;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req    (i_req),
    .i_ptr    (w_ptr_in),
    .o_pick_c (w_pick),
    .o_any_c  (w_any)
  );

  // One-hot operand mux for the selected mover.
  always_comb begin
    w_pick_idx = '0;
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_dir  = RIGHT;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PTR_W'(i);
        w_sel_x    = i_req_x[i*COORD_W +: COORD_W];
        w_sel_y    = i_req_y[i*COORD_W +: COORD_W];
        w_sel_dir  = dir_t'(i_req_dir[2*i +: 2]);
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_win_idx_nxt      = r_win_idx;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_q_x_nxt          = o_q_x;
    w_q_y_nxt          = o_q_y;
    w_q_dir_nxt        = o_q_dir;
    w_resp_blocked_nxt = o_resp_blocked;
    w_load             = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_wait_cnt_nxt = WAIT_INIT;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        if (r_wait_cnt == '0) begin
          w_resp_blocked_nxt[r_win_idx] = i_q_blocked;
          w_state_nxt                   = RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        w_rr_ptr_nxt = w_ptr_after;
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Abort drops any in-flight verdict and restarts the rotation.
    if (i_flush) begin
      w_state_nxt        = IDLE;
      w_rr_ptr_nxt       = '0;
      w_resp_blocked_nxt = '0;
      w_load             = 1'b0;
    end

    if (w_load) begin
      w_win_idx_nxt = w_pick_idx;
      w_q_x_nxt     = w_sel_x;
      w_q_y_nxt     = w_sel_y;
      w_q_dir_nxt   = w_sel_dir;
    end

    w_q_valid_nxt    = (w_state_nxt == ISSUE);
    w_busy_nxt       = (w_state_nxt != IDLE);
    w_gnt_nxt        = '0;
    w_resp_valid_nxt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gnt_nxt[i]        = w_q_valid_nxt && (w_win_idx_nxt == PTR_W'(i));
      w_resp_valid_nxt[i] = (w_state_nxt == RESP) && (r_win_idx == PTR_W'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_win_idx      <= '0;
      r_wait_cnt     <= '0;
      o_q_valid      <= 1'b0;
      o_q_x          <= '0;
      o_q_y          <= '0;
      o_q_dir        <= '0;
      o_gnt          <= '0;
      o_resp_valid   <= '0;
      o_resp_blocked <= '0;
      o_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_win_idx      <= w_win_idx_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      o_q_valid      <= w_q_valid_nxt;
      o_q_x          <= w_q_x_nxt;
      o_q_y          <= w_q_y_nxt;
      o_q_dir        <= w_q_dir_nxt;
      o_gnt          <= w_gnt_nxt;
      o_resp_valid   <= w_resp_valid_nxt;
      o_resp_blocked <= w_resp_blocked_nxt;
      o_busy         <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_wall_query_arbiter.sv
// Directed and random checks of wall_query_arbiter against a transaction-timeline reference model.
module tb_wall_query_arbiter;

  localparam int N   = 5;
  localparam int LAT = 2;
  localparam int CW  = 10;

  logic            clk, rst_n, flush, q_blocked;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_x, req_y;
  logic [2*N-1:0]  req_dir;
  logic            q_valid, busy;
  logic [CW-1:0]   q_x, q_y;
  logic [1:0]      q_dir;
  logic [N-1:0]    gnt, resp_valid, resp_blocked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one transaction timeline plus rotation pointer and held verdicts.
  int            m_ptr, m_win, m_gnt_c, m_samp_c, m_resp_c;
  logic [N-1:0]  m_rb;
  logic [CW-1:0] m_qx, m_qy;
  logic [1:0]    m_qd;

  wall_query_arbiter #(.N_REQ(N), .LOOKUP_LAT(LAT), .COORD_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_req(req),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_dir(req_dir),
    .o_q_valid(q_valid), .o_q_x(q_x), .o_q_y(q_y), .o_q_dir(q_dir),
    .i_q_blocked(q_blocked), .o_gnt(gnt), .o_resp_valid(resp_valid),
    .o_resp_blocked(resp_blocked), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_win = 0; m_gnt_c = -100; m_samp_c = -100; m_resp_c = -100;
    m_rb = '0; m_qx = '0; m_qy = '0; m_qd = '0;
  endtask

  // Apply the rules to the inputs seen during cycle c, then advance and compare cycle c+1.
  task automatic tick();
    int c;
    bit found;
    int idx;
    logic [N-1:0] eg, er;
    c = cyc;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      m_ptr = 0; m_rb = '0; m_gnt_c = -100; m_samp_c = -100; m_resp_c = -100;
    end else begin
      if (c == m_samp_c) m_rb[m_win] = q_blocked;
      if (c == m_resp_c) m_ptr = (m_win + 1) % N;
      if (c >= m_resp_c && req != '0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && req[idx]) begin
            found = 1;
            m_win = idx;
          end
        end
        m_gnt_c  = c + 1;
        m_samp_c = c + 1 + LAT;
        m_resp_c = c + 2 + LAT;
        m_qx = req_x[m_win*CW +: CW];
        m_qy = req_y[m_win*CW +: CW];
        m_qd = req_dir[2*m_win +: 2];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    eg = '0;
    er = '0;
    if (cyc == m_gnt_c)  eg[m_win] = 1'b1;
    if (cyc == m_resp_c) er[m_win] = 1'b1;
    chk("q_valid",      32'(q_valid),      32'(cyc == m_gnt_c));
    chk("gnt",          32'(gnt),          32'(eg));
    chk("resp_valid",   32'(resp_valid),   32'(er));
    chk("resp_blocked", 32'(resp_blocked), 32'(m_rb));
    chk("busy",         32'(busy),         32'(cyc >= m_gnt_c && cyc <= m_resp_c));
    chk("q_x",          32'(q_x),          32'(m_qx));
    chk("q_y",          32'(q_y),          32'(m_qy));
    chk("q_dir",        32'(q_dir),        32'(m_qd));
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int k = 0; k < 40 && idx < 0; k++) begin
      tick();
      for (int j = 0; j < N; j++) if (gnt[j]) idx = j;
    end
    chk("gnt_seen", 32'(idx >= 0), 32'd1);
  endtask

  task automatic wait_resp();
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = (resp_valid != '0);
    end
    chk("resp_seen", 32'(seen), 32'd1);
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_ops(input int i, input int x, input int y, input int d);
    req_x[i*CW +: CW] = CW'(x);
    req_y[i*CW +: CW] = CW'(y);
    req_dir[2*i +: 2] = 2'(d);
  endtask

  initial begin
    int t0, g, gprev, prev_c;
    rst_n = 1'b0; flush = 1'b0; q_blocked = 1'b0; req = '0;
    req_x = '0; req_y = '0; req_dir = '0;
    model_reset();
    idle_ticks(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rb",   32'(resp_blocked), 32'd0);
    rst_n = 1'b1;
    idle_ticks(2);

    // Single request from Pac-Man, lookup reports blocked.
    set_ops(0, 136, 248, 0);
    q_blocked = 1'b1;
    req = 5'b00001;
    t0 = cyc;
    wait_gnt(g);
    chk("p1_gnt_idx", 32'(g), 32'd0);
    chk("p1_gnt_lat", 32'(cyc - t0), 32'd1);
    chk("p1_qx", 32'(q_x), 32'd136);
    chk("p1_qy", 32'(q_y), 32'd248);
    req = '0;
    wait_resp();
    chk("p1_resp_lat", 32'(cyc - t0), 32'(LAT + 2));
    chk("p1_rb0", 32'(resp_blocked[0]), 32'd1);
    tick();
    chk("p1_busy_low", 32'(busy), 32'd0);

    // All five requesting: strict rotation, LAT+2 spacing.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 10 * i + 1, 20 * i + 2, i % 4);
    req = '1;
    prev_c = 0;
    for (int k = 0; k < 6; k++) begin
      q_blocked = 1'($urandom);
      wait_gnt(g);
      chk("p2_order", 32'(g), 32'(k % N));
      if (k > 0) chk("p2_spacing", 32'(cyc - prev_c), 32'(LAT + 2));
      prev_c = cyc;
    end
    req = '0;
    idle_ticks(6);

    // Fairness: mover 3 arrives while 0 is in flight and goes next.
    flush = 1'b1; tick(); flush = 1'b0;
    req = 5'b00001;
    wait_gnt(g);
    chk("p3_first", 32'(g), 32'd0);
    tick();
    req = 5'b01001;
    wait_gnt(g);
    chk("p3_second", 32'(g), 32'd3);
    wait_gnt(g);
    chk("p3_third", 32'(g), 32'd0);
    req = '0;
    idle_ticks(6);

    // Operands changed after grant must not reach the in-flight query.
    flush = 1'b1; tick(); flush = 1'b0;
    set_ops(2, 100, 55, 2);
    req = 5'b00100;
    wait_gnt(g);
    chk("p4_gnt", 32'(g), 32'd2);
    set_ops(2, 200, 66, 3);
    req = '0;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      chk("p4_qx_hold", 32'(q_x), 32'd100);
    end
    idle_ticks(3);

    // Flush during WAIT, after moving the pointer away from 0.
    q_blocked = 1'b1;
    req = 5'b01000;
    wait_gnt(g);
    req = '0;
    wait_resp();
    chk("p5_rb3", 32'(resp_blocked[3]), 32'd1);
    idle_ticks(2);
    req = 5'b00010;
    wait_gnt(g);
    chk("p5_gnt1", 32'(g), 32'd1);
    req = '0;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("p5_rb_clr", 32'(resp_blocked), 32'd0);
    chk("p5_idle",   32'(busy), 32'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("p5_no_resp", 32'(resp_valid), 32'd0);
    end
    req = 5'b10010;
    wait_gnt(g);
    chk("p5_after_a", 32'(g), 32'd1);
    wait_gnt(g);
    chk("p5_after_b", 32'(g), 32'd4);
    req = '0;
    idle_ticks(6);

    // Random traffic with occasional flush.
    for (int k = 0; k < 600; k++) begin
      req = N'($urandom);
      for (int i = 0; i < N; i++)
        set_ops(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 31) == 0);
      q_blocked = 1'($urandom);
      tick();
    end
    flush = 1'b0; req = '0;
    idle_ticks(6);

    // Asynchronous reset in the middle of WAIT.
    req = 5'b00001;
    q_blocked = 1'b1;
    wait_gnt(g);
    req = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_q_valid", 32'(q_valid), 32'd0);
    chk("ar_gnt",     32'(gnt), 32'd0);
    chk("ar_resp",    32'(resp_valid), 32'd0);
    chk("ar_rb",      32'(resp_blocked), 32'd0);
    chk("ar_busy",    32'(busy), 32'd0);
    chk("ar_qx",      32'(q_x), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      chk("ar_no_resp", 32'(resp_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
